board_io_ctrl: RTL and testbench

//  Board-side glue between the FPGA top and Grande_Risco_5_SOC, parametrised for any board.
//  - Conditions the raw board reset into a synchronised, stretched SoC reset.
//  - Debounces NUM_BUTTONS push-buttons into clean levels plus rising-edge pulses.
//  - Maps the SoC's SOC_LEDS_WIDTH-bit LED bus onto NUM_LEDS board LEDs.
//    The mapping is selectable by mode, with PWM brightness control.

---
 rtl/board_io_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_board_io_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// Board-side glue for the SoC: reset conditioning, button debouncing and
// mode-selectable LED mapping with PWM brightness and a heartbeat.
module board_io_ctrl #(
    parameter int unsigned CLOCK_FREQ        = 100000000,
    parameter int unsigned SOC_LEDS_WIDTH    = 16,
    parameter int unsigned NUM_LEDS          = 4,
    parameter int unsigned NUM_BUTTONS       = 4,
    parameter int unsigned DEBOUNCE_MS       = 10,
    parameter int unsigned RESET_HOLD_CYCLES = 1024,
    parameter int unsigned PWM_BITS          = 8,
    parameter int unsigned HEARTBEAT_HZ      = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SOC_LEDS_WIDTH-1:0] soc_leds,
    input  logic [1:0]                led_mode,
    input  logic [PWM_BITS-1:0]       brightness,
    input  logic [NUM_BUTTONS-1:0]    btn_raw,
    output logic                      soc_rst_n,
    output logic [NUM_BUTTONS-1:0]    btn_level,
    output logic [NUM_BUTTONS-1:0]    btn_pulse,
    output logic [NUM_LEDS-1:0]       led
);

    localparam int unsigned DB_CYCLES = CLOCK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int unsigned DB_W      = $clog2(DB_CYCLES + 1);
    localparam int unsigned HB_HALF   = CLOCK_FREQ / (2 * HEARTBEAT_HZ);
    localparam int unsigned HB_W      = $clog2(HB_HALF + 1);
    localparam int unsigned RH_W      = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int unsigned FOLD_N    = (SOC_LEDS_WIDTH + NUM_LEDS - 1) / NUM_LEDS;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Reset sequencer
    // ------------------------------------------------------------------
    logic [1:0]      rst_sync_q, rst_sync_d;
    state_t          state_q, state_d;
    logic [RH_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            soc_rst_n_q, soc_rst_n_d;

    always_comb begin
        rst_sync_d  = {rst_sync_q[0], 1'b1};
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        soc_rst_n_d = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (rst_sync_q[1]) begin
                    if (hold_cnt_q == RH_W'(RESET_HOLD_CYCLES - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + RH_W'(1);
                    end
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_HOLD;
        endcase
        // Registered so the first high cycle coincides with the first RUN cycle.
        soc_rst_n_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q  <= '0;
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            soc_rst_n_q <= 1'b0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            soc_rst_n_q <= soc_rst_n_d;
        end
    end

    assign soc_rst_n = soc_rst_n_q;

    // ------------------------------------------------------------------
    // Button debouncers, one independent instance per button
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
        logic            s1_q, s1_d;
        logic            s2_q, s2_d;
        logic            level_q, level_d;
        logic            pulse_q, pulse_d;
        logic [DB_W-1:0] cnt_q, cnt_d;

        always_comb begin
            s1_d    = btn_raw[g];
            s2_d    = s1_q;
            level_d = level_q;
            cnt_d   = '0;
            if (s2_q != level_q) begin
                if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
                    level_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            pulse_d = level_d & ~level_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                s1_q    <= s1_d;
                s2_q    <= s2_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
                cnt_q   <= cnt_d;
            end
        end

        assign btn_level[g] = level_q;
        assign btn_pulse[g] = pulse_q;
    end

    // ------------------------------------------------------------------
    // Heartbeat, PWM and LED mapping
    // ------------------------------------------------------------------
    logic [HB_W-1:0]     hb_cnt_q, hb_cnt_d;
    logic                hb_q, hb_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [NUM_LEDS-1:0] pat_fold;
    logic [NUM_LEDS-1:0] pat;
    logic                pwm_on;

    always_comb begin
        hb_cnt_d = hb_cnt_q + HB_W'(1);
        hb_d     = hb_q;
        if (hb_cnt_q == HB_W'(HB_HALF - 1)) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
        end
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

        // Fold the SoC bus onto the board LEDs one NUM_LEDS-wide slice at a time.
        pat_fold = '0;
        for (int c = 0; c < FOLD_N; c++) begin
            pat_fold = pat_fold | NUM_LEDS'(soc_leds >> (c * NUM_LEDS));
        end

        pat = soc_leds[NUM_LEDS-1:0];
        case (led_mode)
            2'b00: pat = soc_leds[NUM_LEDS-1:0];
            2'b01: pat = pat_fold;
            2'b10: pat[0] = hb_q;
            2'b11: pat = {NUM_LEDS{~soc_rst_n_q}};
            default: pat = '0;
        endcase

        pwm_on = (brightness == '1) || (pwm_cnt_q < brightness);
        led_d  = pat & {NUM_LEDS{pwm_on}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q  <= '0;
            hb_q      <= 1'b0;
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            hb_cnt_q  <= hb_cnt_d;
            hb_q      <= hb_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl: directed scenarios plus randomized
// button and LED traffic compared against a cycle-count based reference model.
module tb_board_io_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] soc_leds;
    logic [1:0]  led_mode;
    logic [3:0]  brightness;
    logic [3:0]  btn_raw;
    logic        soc_rst_n;
    logic [3:0]  btn_level;
    logic [3:0]  btn_pulse;
    logic [3:0]  led;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned edges;

    board_io_ctrl #(
        .CLOCK_FREQ       (1000),
        .SOC_LEDS_WIDTH   (16),
        .NUM_LEDS         (4),
        .NUM_BUTTONS      (4),
        .DEBOUNCE_MS      (4),
        .RESET_HOLD_CYCLES(8),
        .PWM_BITS         (4),
        .HEARTBEAT_HZ     (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .soc_leds  (soc_leds),
        .led_mode  (led_mode),
        .brightness(brightness),
        .btn_raw   (btn_raw),
        .soc_rst_n (soc_rst_n),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since the last release of rst_n: time base for the LED model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // Expected LEDs after edge k, from the inputs held during the cycle before it.
    function automatic logic [3:0] led_model(input logic [1:0] m, input logic [15:0] sl,
                                             input logic [3:0] br, input int unsigned k);
        int unsigned pk;
        logic        on;
        logic        hb;
        logic        srun;
        logic [3:0]  p;
        pk   = k - 1;
        on   = (br == 4'hF) || ((pk % 16) < br);
        hb   = ((pk / 500) % 2) == 1;
        srun = pk >= 10;
        case (m)
            2'd0:    p = sl[3:0];
            2'd1:    p = sl[3:0] | sl[7:4] | sl[11:8] | sl[15:12];
            2'd2:    p = {sl[3:1], hb};
            default: p = {4{~srun}};
        endcase
        return on ? p : 4'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_led;
        rst_n      = 1'b0;
        btn_raw    = '0;
        soc_leds   = '0;
        led_mode   = 2'b11;
        brightness = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (soc_rst_n !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_soc_rst_n: got %b expected 0", soc_rst_n);
        end
        vectors++;
        if (btn_level !== 4'h0 || btn_pulse !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_buttons: got level %h pulse %h expected 0 0", btn_level, btn_pulse);
        end
        vectors++;
        if (led !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_led: got %h expected 0", led);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            vectors++;
            if (soc_rst_n !== (n >= 10)) begin
                miscompares++;
                $display("FAIL release_soc_rst_n edge %0d: got %b expected %b", n, soc_rst_n, n >= 10);
            end
            exp_led = led_model(led_mode, soc_leds, brightness, edges);
            vectors++;
            if (led !== exp_led) begin
                miscompares++;
                $display("FAIL hold_led_mode11 edge %0d: got %h expected %h", n, led, exp_led);
            end
        end
        // Short glitch while in RUN
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (soc_rst_n !== 1'b0 || led !== 4'h0) begin
            miscompares++;
            $display("FAIL glitch_async: got soc_rst_n %b led %h expected 0 0", soc_rst_n, led);
        end
        #1 rst_n = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick();
            vectors++;
            if (soc_rst_n !== (n >= 10)) begin
                miscompares++;
                $display("FAIL glitch_release edge %0d: got %b expected %b", n, soc_rst_n, n >= 10);
            end
        end
    endtask

    task automatic test_debounce();
        logic [3:0] pat;
        tick();
        btn_raw[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            vectors++;
            if (btn_level[0] !== (n >= 6) || btn_pulse[0] !== (n == 6)) begin
                miscompares++;
                $display("FAIL press_btn0 edge %0d: got level %b pulse %b expected %b %b",
                         n, btn_level[0], btn_pulse[0], n >= 6, n == 6);
            end
        end
        pat = 4'b0111;
        for (int n = 0; n < 20; n++) begin
            btn_raw[1] = (n < 16) ? pat[n % 4] : 1'b0;
            tick();
            vectors++;
            if (btn_level[1] !== 1'b0 || btn_pulse[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL bounce_btn1 cycle %0d: got level %b pulse %b expected 0 0",
                         n, btn_level[1], btn_pulse[1]);
            end
        end
        btn_raw[0] = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            vectors++;
            if (btn_level[0] !== (n < 6) || btn_pulse[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL release_btn0 edge %0d: got level %b pulse %b expected %b 0",
                         n, btn_level[0], btn_pulse[0], n < 6);
            end
        end
    endtask

    task automatic test_debounce_random();
        logic [3:0] hist[$];
        logic [3:0] exp_lvl;
        logic [3:0] exp_pulse;
        logic       all_diff;
        exp_lvl = '0;
        for (int i = 0; i < 6; i++) hist.push_back(4'h0);
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) btn_raw[b] = ~btn_raw[b];
            end
            tick();
            hist.push_back(btn_raw);
            // The synchronised view lags the raw input by two edges; a level change
            // needs four consecutive synchronised samples differing from the level.
            exp_pulse = '0;
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                for (int j = 2; j <= 5; j++) begin
                    if (hist[$-j][b] == exp_lvl[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    exp_lvl[b]   = ~exp_lvl[b];
                    exp_pulse[b] = exp_lvl[b];
                end
            end
            void'(hist.pop_front());
            vectors++;
            if (btn_level !== exp_lvl) begin
                miscompares++;
                $display("FAIL rand_level cycle %0d: got %h expected %h", n, btn_level, exp_lvl);
            end
            vectors++;
            if (btn_pulse !== exp_pulse) begin
                miscompares++;
                $display("FAIL rand_pulse cycle %0d: got %h expected %h", n, btn_pulse, exp_pulse);
            end
        end
        btn_raw = '0;
        repeat (8) tick();
    endtask

    task automatic test_led_modes();
        brightness = 4'hF;
        soc_leds   = 16'h0100;
        led_mode   = 2'b00;
        tick();
        vectors++;
        if (led !== 4'h0) begin
            miscompares++;
            $display("FAIL mode00_0100: got %h expected 0", led);
        end
        led_mode = 2'b01;
        tick();
        vectors++;
        if (led !== 4'h1) begin
            miscompares++;
            $display("FAIL mode01_0100: got %h expected 1", led);
        end
        soc_leds = 16'h8421;
        tick();
        vectors++;
        if (led !== 4'hF) begin
            miscompares++;
            $display("FAIL mode01_8421: got %h expected f", led);
        end
    endtask

    task automatic test_pwm();
        int         on_cnt;
        logic [3:0] br_list[3];
        int         exp_on[3];
        br_list = '{4'h4, 4'h0, 4'hF};
        exp_on  = '{4, 0, 16};
        led_mode = 2'b00;
        soc_leds = 16'h000F;
        for (int t = 0; t < 3; t++) begin
            brightness = br_list[t];
            on_cnt = 0;
            for (int n = 0; n < 16; n++) begin
                tick();
                if (led === 4'hF) on_cnt++;
                vectors++;
                if (led !== led_model(led_mode, soc_leds, brightness, edges)) begin
                    miscompares++;
                    $display("FAIL pwm_cycle br %h cycle %0d: got %h expected %h", brightness, n, led,
                             led_model(led_mode, soc_leds, brightness, edges));
                end
            end
            vectors++;
            if (on_cnt != exp_on[t]) begin
                miscompares++;
                $display("FAIL pwm_duty br %h: got %0d on cycles expected %0d", brightness, on_cnt, exp_on[t]);
            end
        end
    endtask

    task automatic test_heartbeat();
        logic        prev;
        int unsigned t_edges[$];
        led_mode   = 2'b10;
        soc_leds   = 16'h0000;
        brightness = 4'hF;
        tick();
        prev = led[0];
        for (int n = 0; n < 1100; n++) begin
            tick();
            vectors++;
            if (led !== led_model(led_mode, soc_leds, brightness, edges)) begin
                miscompares++;
                $display("FAIL heartbeat_led edge %0d: got %h expected %h", edges, led,
                         led_model(led_mode, soc_leds, brightness, edges));
            end
            if (led[0] !== prev) t_edges.push_back(edges);
            prev = led[0];
        end
        vectors++;
        if (t_edges.size() < 2 || (t_edges[1] - t_edges[0]) != 500) begin
            miscompares++;
            $display("FAIL heartbeat_period: got %0d toggles, gap %0d expected gap 500", t_edges.size(),
                     (t_edges.size() >= 2) ? int'(t_edges[1] - t_edges[0]) : 0);
        end
        led_mode = 2'b11;
        tick();
        vectors++;
        if (led !== 4'h0) begin
            miscompares++;
            $display("FAIL mode11_run: got %h expected 0", led);
        end
    endtask

    task automatic test_led_random();
        logic [3:0] exp_led;
        for (int n = 0; n < 300; n++) begin
            led_mode   = 2'($urandom);
            soc_leds   = 16'($urandom);
            brightness = 4'($urandom_range(0, 15));
            tick();
            exp_led = led_model(led_mode, soc_leds, brightness, edges);
            vectors++;
            if (led !== exp_led) begin
                miscompares++;
                $display("FAIL rand_led mode %b sl %h br %h: got %h expected %h",
                         led_mode, soc_leds, brightness, led, exp_led);
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_debounce_random();
        test_led_modes();
        test_pwm();
        test_heartbeat();
        test_led_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
